if_prefetch_unit: RTL and testbench
===================================

# if_prefetch_unit

Instruction fetch front end sitting directly upstream of the IF/ID pipeline register. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel with in-order responses, and buffers returned instructions in a small prefetch queue. It presents one `{pc, instr}` pair per cycle to IF/ID. It honours hazard stalls (`id_ready` low) and branch redirects from the MEM stage, discarding in-flight responses made stale by a redirect.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; also the maximum number of outstanding requests (power of two, ≥2).
- `XLEN`, 64: PC width.
- `ILEN`, 32: instruction width.
- `RESET_PC`, 64'h0: first fetch address.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out XLEN: fetch address, word aligned.
- `imem_rsp_valid` in 1: response valid; responses return in request order, any latency ≥1.
- `imem_rsp_data` in ILEN: fetched instruction.
- `redirect` in 1: taken branch (PCsrc) from MEM.
- `redirect_pc` in XLEN: branch target.
- `id_ready` in 1: IF/ID write enable; low means stall.
- `if_valid` out 1: `if_pc`/`if_instr` hold a real instruction.
- `if_pc` out XLEN: PC of the presented instruction.
- `if_instr` out ILEN: presented instruction; NOP (32'h00000013) when `if_valid` is 0.

## Operation
- State:
  - `fetch_pc`
  - queue: `count` in 0..DEPTH
  - `outstanding` in 0..DEPTH (accepted requests without a response)
  - `drop_cnt` in 0..DEPTH (responses still to discard)
  - a per-request PC tag FIFO (depth DEPTH)
- Issue:
  - `imem_req_valid = !redirect && (count + outstanding < DEPTH)`.
  - `imem_req_addr = fetch_pc`.
  - On accept: push `fetch_pc` to the tag FIFO, `fetch_pc += 4`, `outstanding++`.
- Response:
  - `outstanding--`.
  - If `drop_cnt > 0`: `drop_cnt--` and discard.
  - Otherwise pop the tag and push `{tag, data}` into the queue.
- Delivery: `if_valid = (count != 0)`. A pop occurs when `if_valid && id_ready`.
- Redirect (highest priority):
  - Queue is cleared; a same-cycle pop is ignored.
  - `fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}`.
  - `drop_cnt <=` outstanding after this cycle's accounting. A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
- Simultaneous push and pop are both performed; the credit rule guarantees a response never overflows the queue.
- A response with `outstanding == 0` is a protocol error: ignore it; the bench asserts on it.
- Counter widths: `$clog2(DEPTH+1)` bits. The PC wraps modulo 2^XLEN.

## Timing
- Reset values:
  - `imem_req_valid` 0 while `rst_n` low.
  - `imem_req_addr = RESET_PC`.
  - `if_valid` 0, `if_pc` 0, `if_instr` NOP.
  - All counters 0.
- First request is valid in the first cycle after reset deassertion.
- `imem_req_addr` is stable while `imem_req_valid && !imem_req_ready`. It changes only on accept or redirect.
- Latency from response to `if_valid`: 1 cycle (queue registered).
- Steady-state throughput: 1 instr/cycle when memory has 1-cycle latency and `id_ready` is high.
- Redirect at cycle t: first request at the new PC in cycle t+1. Earliest `if_valid` at the new PC is t+3 with 1-cycle memory.
- Reset asserted mid-operation clears all state immediately. Responses arriving after reset release with `outstanding == 0` are ignored.

## Configuration
- `IF_BYPASS_EN` defined:
  - When `count == 0` and a non-dropped response arrives, it drives `if_valid`/`if_pc`/`if_instr` combinationally in the same cycle.
  - If `id_ready` is also high, it is consumed without entering the queue. Response-to-output latency becomes 0.
  - Redirect still suppresses the bypass.
- `IF_BYPASS_EN` undefined: all responses pass through the queue (1-cycle latency).

## Structure
- Shared package `rv_pkg`:
  - NOP encoding constant.
  - `XLEN`/`ILEN` defaults.
  - Fetch-entry type `{pc, instr}`.
- Sub-module `fetch_fifo`: synchronous FIFO of DEPTH entries with push, pop and single-cycle flush. It is instantiated twice: once for the queue, once for the PC tags.
- Issue/drop counters live in the top level.

## Test plan
- Reset, zero-latency-ready memory, `id_ready=1` -> requests to 0x0, 0x4, 0x8 on consecutive cycles. `if_pc` sequence 0x0, 0x4, 0x8 starting 2 cycles after the first accept.
- `id_ready=0` for 10 cycles -> exactly DEPTH=4 requests accepted, then `imem_req_valid` held 0. `if_pc` held constant. Release -> 0x0..0xC delivered back to back.
- `imem_req_ready=0` for 3 cycles -> `imem_req_addr` stays 0x8 throughout.
- Memory latency 3 with 3 outstanding, `redirect=1`, `redirect_pc=0x102` -> all 3 stale responses dropped. Next `if_pc` is 0x100, followed by 0x104.
- Redirect in the same cycle as a response and a pop -> queue empty next cycle. That response is discarded; no instruction from the old path appears.
- With `IF_BYPASS_EN`, queue empty, response 0x00500093 at PC 0x20 -> `if_valid=1`, `if_instr=0x00500093` in the same cycle. Without the macro, it appears one cycle later.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-path definitions: default widths, the NOP encoding and the
// {pc, instr} entry type handed from fetch to decode.
package rv_pkg;

  localparam int DEFAULT_XLEN = 64;
  localparam int DEFAULT_ILEN = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop and a single-cycle flush; read data is the
// current head and is only meaningful while count is non-zero.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the pointers wrap on their own.
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch front end: PC ownership, credit-limited imem requests,
// stale-response dropping after redirects and an IF/ID-facing prefetch queue.
// Define IF_BYPASS_EN to forward a response straight to the outputs when the queue is empty.
module if_prefetch_unit import rv_pkg::*; #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              ILEN     = DEFAULT_ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = XLEN + ILEN;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   tag_count;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     credit_sum;
  logic [XLEN-1:0] tag_pc;
  logic [EW-1:0]   q_data;
  logic            req_fire;
  logic            rsp_legal;
  logic            rsp_keep;
  logic            tag_pop;
  logic            bypass;
  logic            q_push;
  logic            q_pop;
  logic [XLEN-1:0] sel_pc;
  logic [ILEN-1:0] sel_instr;

  // Every live tag belongs to a response still owed, and a redirect moves the
  // whole owed count into drop_cnt while flushing the tags.
  assign outstanding = tag_count + drop_cnt;
  assign credit_sum  = {1'b0, q_count} + {1'b0, outstanding};

  assign imem_req_valid = rst_n && !redirect && (credit_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_legal = imem_rsp_valid && (outstanding != '0);
  assign tag_pop   = rsp_legal && (drop_cnt == '0);
  assign rsp_keep  = tag_pop && !redirect;

`ifdef IF_BYPASS_EN
  assign bypass = rsp_keep && (q_count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign q_push = rsp_keep && !(bypass && id_ready);
  assign q_pop  = (q_count != '0) && id_ready;

  assign sel_pc    = bypass ? tag_pc : q_data[EW-1:ILEN];
  assign sel_instr = bypass ? imem_rsp_data : q_data[ILEN-1:0];

  assign if_valid = (q_count != '0) || bypass;
  assign if_pc    = if_valid ? sel_pc : '0;
  assign if_instr = if_valid ? sel_instr : ILEN'(NOP);

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (tag_pop),
    .pop_data  (tag_pc),
    .count     (tag_count)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (q_push),
    .push_data ({tag_pc, imem_rsp_data}),
    .pop       (q_pop),
    .pop_data  (q_data),
    .count     (q_count)
  );

  // A redirect discards every response still owed, including one arriving now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      drop_cnt <= outstanding - CW'(rsp_legal);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (rsp_legal && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with a latency-configurable memory model
// and a scoreboard of expected {pc, instr} deliveries.
module tb_if_prefetch_unit;
  import rv_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  logic            clk;
  logic            rst_n;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;

  pend_t        pend[$];
  fetch_entry_t sb[$];
  logic [63:0]  deliv[$];
  logic [63:0]  exp_addr;
  int           cyc, lat, fires, delivs, first_valid;
  int           checks, errors;
  logic         s_req_valid, s_if_valid;
  logic [63:0]  s_req_addr, s_if_pc;
  logic [31:0]  s_if_instr;

  if_prefetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] memfn(input logic [63:0] a);
    if (a == 64'h20) return 32'h0050_0093;
    return {a[21:2], 12'h093};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory responds at the falling edge, outputs are sampled
  // just after, and the bench resumes 1 time unit past the rising edge.
  task automatic tick();
    fetch_entry_t e;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_instr  = if_instr;
    if (!if_valid) begin
      check("idle_instr", if_instr, 64'(NOP));
      check("idle_pc", if_pc, 64'h0);
    end
    if (redirect) begin
      check("redirect_no_req", imem_req_valid, 64'h0);
      sb.delete();
      deliv.delete();
      exp_addr = redirect_pc & ~64'h3;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_addr);
        pend.push_back('{addr: imem_req_addr, due: cyc + lat});
        sb.push_back('{pc: exp_addr, instr: memfn(exp_addr)});
        exp_addr += 64'h4;
        fires++;
      end
      if (if_valid && id_ready) begin
        if (first_valid < 0) first_valid = cyc;
        delivs++;
        deliv.push_back(if_pc);
        check("sb_nonempty", 64'(sb.size() != 0), 64'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("deliver_pc", if_pc, e.pc);
          check("deliver_instr", if_instr, 64'(e.instr));
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    #1;
    check("rst_req_valid", imem_req_valid, 64'h0);
    check("rst_req_addr", imem_req_addr, 64'h0);
    check("rst_if_valid", if_valid, 64'h0);
    check("rst_if_pc", if_pc, 64'h0);
    check("rst_if_instr", if_instr, 64'(NOP));
    @(posedge clk);
    #1;
    pend.delete();
    sb.delete();
    deliv.delete();
    exp_addr    = 64'h0;
    fires       = 0;
    delivs      = 0;
    first_valid = -1;
    lat         = 1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    lat    = 1;

    // Streaming with single-cycle memory.
    apply_reset();
    release_reset();
    tick();
    check("first_req_valid", s_req_valid, 64'h1);
    check("first_req_addr", s_req_addr, 64'h0);
    repeat (11) tick();
    check("stream_fires", fires, 12);
`ifdef IF_BYPASS_EN
    check("first_valid_cycle", first_valid, 1);
    check("stream_delivs", delivs, 11);
`else
    check("first_valid_cycle", first_valid, 2);
    check("stream_delivs", delivs, 10);
`endif

    // Decode stalled: credits cap accepted requests at DEPTH.
    apply_reset();
    id_ready = 1'b0;
    release_reset();
    repeat (10) tick();
    check("stall_fires", fires, DEPTH);
    check("stall_req_valid", s_req_valid, 64'h0);
    check("stall_if_valid", s_if_valid, 64'h1);
    check("stall_if_pc", s_if_pc, 64'h0);
    id_ready = 1'b1;
    repeat (4) tick();
    check("release_delivs", delivs, 4);
    if (deliv.size() >= 4) check("release_last_pc", deliv[3], 64'hC);
    repeat (4) tick();

    // Memory back-pressure holds the request address.
    apply_reset();
    release_reset();
    repeat (2) tick();
    imem_req_ready = 1'b0;
    repeat (3) begin
      tick();
      check("hold_req_valid", s_req_valid, 64'h1);
      check("hold_req_addr", s_req_addr, 64'h8);
    end
    imem_req_ready = 1'b1;
    repeat (6) tick();

    // Redirect with three requests in flight at latency 3.
    apply_reset();
    lat = 3;
    release_reset();
    repeat (3) tick();
    check("lat3_fires", fires, 3);
    redirect    = 1'b1;
    redirect_pc = 64'h102;
    tick();
    redirect = 1'b0;
    tick();
    check("redir_req_valid", s_req_valid, 64'h1);
    check("redir_req_addr", s_req_addr, 64'h100);
    for (int i = 0; i < 20 && deliv.size() < 2; i++) tick();
    check("redir_delivs", 64'(deliv.size() >= 2), 64'h1);
    if (deliv.size() >= 2) begin
      check("redir_pc0", deliv[0], 64'h100);
      check("redir_pc1", deliv[1], 64'h104);
    end
    repeat (3) tick();

    // Redirect colliding with a response and a pop; then bypass timing.
    apply_reset();
    release_reset();
    repeat (5) tick();
    redirect    = 1'b1;
    redirect_pc = 64'h20;
    tick();
`ifdef IF_BYPASS_EN
    check("coll_if_valid", s_if_valid, 64'h0);
`else
    check("coll_if_valid", s_if_valid, 64'h1);
`endif
    redirect = 1'b0;
    tick();
    check("post_redir_if_valid", s_if_valid, 64'h0);
    check("post_redir_req_valid", s_req_valid, 64'h1);
    check("post_redir_req_addr", s_req_addr, 64'h20);
    tick();
`ifdef IF_BYPASS_EN
    check("bypass_if_valid", s_if_valid, 64'h1);
    check("bypass_if_pc", s_if_pc, 64'h20);
    check("bypass_if_instr", s_if_instr, 64'h0050_0093);
`else
    check("nobypass_if_valid", s_if_valid, 64'h0);
    check("nobypass_if_instr", s_if_instr, 64'(NOP));
`endif
    tick();
`ifdef IF_BYPASS_EN
    check("bypass_next_pc", s_if_pc, 64'h24);
`else
    check("queued_if_valid", s_if_valid, 64'h1);
    check("queued_if_pc", s_if_pc, 64'h20);
    check("queued_if_instr", s_if_instr, 64'h0050_0093);
`endif
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
